// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory arbiter.
// Holds FSM state/grant encodings, width defaults and the grant picker.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  function automatic grant_t other_port(grant_t g);
    return (g == GNT_I) ? GNT_D : GNT_I;
  endfunction

  // Only meaningful when at least one req is high.
  function automatic grant_t arb_pick(
    logic   ireq,
    logic   dreq,
    grant_t last,
    bit     rr
  );
    if (!ireq) return GNT_D;
    if (!dreq) return GNT_I;
    return rr ? other_port(last) : GNT_D;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: loadable down-counter, expires on the TIMEOUT-th enabled cycle.
// Ports: clock, reset, clear, load (reload TIMEOUT), en (count), expired.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW =
    (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit WD_ON = (TIMEOUT != 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(TIMEOUT);
    end else if (en && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // cnt==1 marks the last allowed busy cycle; 0 disables.
  assign expired = WD_ON && en && (cnt == CW'(1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between icache fetch and dcache load/store.
// Ports: clock/reset, icache_* and dcache_* req/rdy sides, mem_* port, timeout_err.
// Define MEM_ARB_RR_EN for round-robin on conflicts; default is dcache priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          ADDR_W  = ADDR_W_DEF,
  parameter int          DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              icache_req,
  output logic [DATA_W-1:0] icache_data,
  output logic              icache_rdy,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [DATA_W-1:0] dcache_wdata,
  input  logic              dcache_req,
  input  logic              dcache_wr,
  output logic [DATA_W-1:0] dcache_rdata,
  output logic              dcache_rdy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              timeout_err
);

`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  arb_state_t state;
  grant_t     gnt;
  grant_t     last_grant;
  grant_t     pick;
  logic       any_req;
  logic       wd_expired;

  assign any_req = icache_req | dcache_req;
  assign pick = arb_pick(icache_req, dcache_req,
                         last_grant, RR_EN);

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == RESP),
    .load    (state == IDLE && any_req),
    .en      (state == BUSY),
    .expired (wd_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      gnt          <= GNT_I;
      last_grant   <= GNT_I;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_req      <= 1'b0;
      mem_wr       <= 1'b0;
      icache_data  <= '0;
      icache_rdy   <= 1'b0;
      dcache_rdata <= '0;
      dcache_rdy   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt        <= pick;
            last_grant <= pick;
            mem_req    <= 1'b1;
            if (pick == GNT_D) begin
              mem_addr  <= dcache_addr;
              mem_wdata <= dcache_wdata;
              mem_wr    <= dcache_wr;
            end else begin
              mem_addr  <= icache_addr;
              mem_wdata <= '0;
              mem_wr    <= 1'b0;
            end
            state <= BUSY;
          end
        end
        BUSY: begin
          if (mem_rdy) begin
            mem_req <= 1'b0;
            mem_wr  <= 1'b0;
            if (gnt == GNT_I) begin
              icache_data <= mem_rdata;
              icache_rdy  <= 1'b1;
            end else begin
              // stores leave the load data register alone
              if (!mem_wr) dcache_rdata <= mem_rdata;
              dcache_rdy <= 1'b1;
            end
            state <= RESP;
          end else if (wd_expired) begin
            mem_req     <= 1'b0;
            mem_wr      <= 1'b0;
            timeout_err <= 1'b1;
            if (gnt == GNT_I) begin
              icache_data <= '0;
              icache_rdy  <= 1'b1;
            end else begin
              dcache_rdata <= '0;
              dcache_rdy   <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          icache_rdy <= 1'b0;
          dcache_rdy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + random transactions vs a transaction-level model.
// TIMEOUT=4 so both normal completions and watchdog aborts are exercised.
module tb_mem_arbiter;

  localparam int TMO = 4;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] icache_addr;
  logic        icache_req;
  logic [31:0] icache_data;
  logic        icache_rdy;
  logic [31:0] dcache_addr;
  logic [31:0] dcache_wdata;
  logic        dcache_req;
  logic        dcache_wr;
  logic [31:0] dcache_rdata;
  logic        dcache_rdy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_rdata;
  logic        mem_rdy;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  // model state
  bit          last_d;
  logic [31:0] m_idata;
  logic [31:0] m_drdata;
  bit          m_terr;

  mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .icache_addr  (icache_addr),
    .icache_req   (icache_req),
    .icache_data  (icache_data),
    .icache_rdy   (icache_rdy),
    .dcache_addr  (dcache_addr),
    .dcache_wdata (dcache_wdata),
    .dcache_req   (dcache_req),
    .dcache_wr    (dcache_wr),
    .dcache_rdata (dcache_rdata),
    .dcache_rdy   (dcache_rdy),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_rdata    (mem_rdata),
    .mem_rdy      (mem_rdy),
    .timeout_err  (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset;
    last_d   = 1'b0;
    m_idata  = '0;
    m_drdata = '0;
    m_terr   = 1'b0;
  endtask

  task automatic chk_data(input string tag);
    chk({tag, "_idata"}, icache_data, m_idata);
    chk({tag, "_drdata"}, dcache_rdata, m_drdata);
    chk({tag, "_terr"}, {31'd0, timeout_err}, {31'd0, m_terr});
  endtask

  // Called in an IDLE cycle; returns in the IDLE cycle after rdy,
  // with the reqs still driven as given.
  task automatic txn(input bit ir, input bit dr, input bit wr,
                     input logic [31:0] ia, input logic [31:0] da,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input int lat);
    bit          win_d;
    bit          ew;
    bit          tmo;
    logic [31:0] ea;
    icache_req   = ir;
    dcache_req   = dr;
    icache_addr  = ia;
    dcache_addr  = da;
    dcache_wdata = wd;
    dcache_wr    = wr;
    mem_rdy      = 1'b0;
    if (ir && dr) win_d = RR ? !last_d : 1'b1;
    else win_d = dr;
    last_d = win_d;
    ea  = win_d ? da : ia;
    ew  = win_d && wr;
    tmo = (lat > TMO);
    tick;
    for (int k = 1; k <= TMO; k++) begin
      chk("busy_req", {31'd0, mem_req}, 32'd1);
      chk("busy_addr", mem_addr, ea);
      chk("busy_wr", {31'd0, mem_wr}, {31'd0, ew});
      if (ew) chk("busy_wdata", mem_wdata, wd);
      chk("busy_irdy", {31'd0, icache_rdy}, 32'd0);
      chk("busy_drdy", {31'd0, dcache_rdy}, 32'd0);
      mem_rdy   = (k == lat);
      mem_rdata = (k == lat) ? rd : $urandom;
      tick;
      mem_rdy = 1'b0;
      if (k == lat) break;
    end
    if (tmo) begin
      m_terr = 1'b1;
      if (win_d) m_drdata = '0;
      else m_idata = '0;
    end else if (!win_d) begin
      m_idata = rd;
    end else if (!wr) begin
      m_drdata = rd;
    end
    chk("resp_req", {31'd0, mem_req}, 32'd0);
    chk("resp_irdy", {31'd0, icache_rdy}, {31'd0, !win_d});
    chk("resp_drdy", {31'd0, dcache_rdy}, {31'd0, win_d});
    chk_data("resp");
    // a late memory answer after an abort must be ignored
    mem_rdy   = tmo;
    mem_rdata = $urandom;
    tick;
    mem_rdy = 1'b0;
    chk("idle_req", {31'd0, mem_req}, 32'd0);
    chk("idle_irdy", {31'd0, icache_rdy}, 32'd0);
    chk("idle_drdy", {31'd0, dcache_rdy}, 32'd0);
    chk_data("idle");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=done");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset        = 1'b1;
    icache_addr  = '0;
    icache_req   = 1'b0;
    dcache_addr  = '0;
    dcache_wdata = '0;
    dcache_req   = 1'b0;
    dcache_wr    = 1'b0;
    mem_rdata    = '0;
    mem_rdy      = 1'b0;
    model_reset();
    tick;
    tick;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_irdy", {31'd0, icache_rdy}, 32'd0);
    chk("rst_drdy", {31'd0, dcache_rdy}, 32'd0);
    chk_data("rst");
    reset = 1'b0;

    // both reqs held from reset: D,D,D,D or D,I,D,I
    for (int n = 0; n < 4; n++)
      txn(1'b1, 1'b1, 1'b0, 32'h1000 + 32'(n), 32'h2000 + 32'(n),
          32'h0, $urandom, 2);

    // fetch, memory answers 2 cycles after mem_req
    txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0,
        32'hDEADBEEF, 3);

    // zero-wait store
    txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 32'h12345678,
        32'hCAFEF00D, 1);

    // load that never completes -> watchdog abort
    txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0,
        32'h55AA55AA, 99);

    // stray mem_rdy in IDLE
    icache_req = 1'b0;
    dcache_req = 1'b0;
    mem_rdy    = 1'b1;
    mem_rdata  = 32'hBADBAD00;
    tick;
    mem_rdy = 1'b0;
    chk("stray_req", {31'd0, mem_req}, 32'd0);
    chk("stray_irdy", {31'd0, icache_rdy}, 32'd0);
    chk("stray_drdy", {31'd0, dcache_rdy}, 32'd0);
    chk_data("stray");
    tick;
    chk("stray2_req", {31'd0, mem_req}, 32'd0);
    chk("stray2_drdy", {31'd0, dcache_rdy}, 32'd0);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(1, 3);
      txn(r[0], r[1], 1'($urandom), $urandom, $urandom,
          $urandom, $urandom, $urandom_range(1, 6));
    end

    // reset in BUSY while mem_rdy arrives
    icache_req  = 1'b0;
    dcache_req  = 1'b1;
    dcache_wr   = 1'b0;
    dcache_addr = 32'h400;
    tick;
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    reset     = 1'b1;
    mem_rdy   = 1'b1;
    mem_rdata = 32'h0BADF00D;
    tick;
    reset      = 1'b0;
    mem_rdy    = 1'b0;
    dcache_req = 1'b0;
    model_reset();
    chk("mrst_req", {31'd0, mem_req}, 32'd0);
    chk("mrst_irdy", {31'd0, icache_rdy}, 32'd0);
    chk("mrst_drdy", {31'd0, dcache_rdy}, 32'd0);
    chk_data("mrst");
    tick;
    chk("mrst2_req", {31'd0, mem_req}, 32'd0);
    chk("mrst2_drdy", {31'd0, dcache_rdy}, 32'd0);
    chk_data("mrst2");

    // arbitration history restarts after reset
    txn(1'b1, 1'b1, 1'b0, 32'h500, 32'h600, 32'h0,
        32'h13579BDF, 2);
    txn(1'b1, 1'b1, 1'b0, 32'h504, 32'h604, 32'h0,
        32'h2468ACE0, 1);
    icache_req = 1'b0;
    dcache_req = 1'b0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
